// File: rtl/aoi_exp_sweep_ctrl.sv
// AOI expander self-test sweep: drives A..D through all 16 vectors, checks Y against ~((A&B)|(C&D)).
// Optional first-failure capture ports are enabled by defining AOI_SWEEP_FAILCAP_EN.
module aoi_exp_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned NUM_PASSES    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       y_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic [3:0] vector,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count
`ifdef AOI_SWEEP_FAILCAP_EN
  ,
  output logic [3:0] first_fail_vec,
  output logic       first_fail_valid
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_e;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] LAST_PASS   = 4'(NUM_PASSES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] vec_q, vec_d;
  logic [3:0] pcnt_q, pcnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [4:0] err_q, err_d;
  logic       mismatch;
  logic       last_vec;
`ifdef AOI_SWEEP_FAILCAP_EN
  logic [3:0] ffv_q, ffv_d;
  logic       ffval_q, ffval_d;
`endif

  assign mismatch = (y_in != ~((vec_q[3] & vec_q[2]) | (vec_q[1] & vec_q[0])));
  assign last_vec = (vec_q == 4'hF) && (pcnt_q == LAST_PASS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      pcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
`ifdef AOI_SWEEP_FAILCAP_EN
      ffv_q   <= '0;
      ffval_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      pcnt_q  <= pcnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
`ifdef AOI_SWEEP_FAILCAP_EN
      ffv_q   <= ffv_d;
      ffval_q <= ffval_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start && !abort) state_d = S_SETTLE;
      S_SETTLE: if (abort) state_d = S_IDLE;
                else if (cnt_q == '0) state_d = S_SAMPLE;
      S_SAMPLE: if (abort) state_d = S_IDLE;
                else if (last_vec) state_d = S_DONE;
                else state_d = S_SETTLE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Registered outputs take their next value here; DONE's effects land on the edge leaving DONE.
  always_comb begin
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    pcnt_d  = pcnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
`ifdef AOI_SWEEP_FAILCAP_EN
    ffv_d   = ffv_q;
    ffval_d = ffval_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          vec_d  = '0;
          pcnt_d = '0;
          err_d  = '0;
          pass_d = 1'b0;
          busy_d = 1'b1;
          cnt_d  = SETTLE_LOAD;
`ifdef AOI_SWEEP_FAILCAP_EN
          ffv_d   = '0;
          ffval_d = 1'b0;
`endif
        end
      end
      S_SETTLE: begin
        if (abort) begin
          busy_d = 1'b0;
          vec_d  = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_SAMPLE: begin
        if (abort) begin
          busy_d = 1'b0;
          vec_d  = '0;
        end else begin
          if (mismatch && err_q != '1) err_d = err_q + 5'd1;
`ifdef AOI_SWEEP_FAILCAP_EN
          if (mismatch && !ffval_q) begin
            ffv_d   = vec_q;
            ffval_d = 1'b1;
          end
`endif
          if (!last_vec) begin
            vec_d = vec_q + 4'd1;
            if (vec_q == 4'hF) pcnt_d = pcnt_q + 4'd1;
            cnt_d = SETTLE_LOAD;
          end
        end
      end
      S_DONE: begin
        busy_d = 1'b0;
        vec_d  = '0;
        if (!abort) begin
          done_d = 1'b1;
          pass_d = (err_q == '0);
        end
      end
      default: ;
    endcase
  end

  assign {a, b, c, d} = vec_q;
  assign vector       = vec_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign err_count    = err_q;
`ifdef AOI_SWEEP_FAILCAP_EN
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffval_q;
`endif

endmodule

// File: tb/tb_aoi_exp_sweep_ctrl.sv
// Bench for aoi_exp_sweep_ctrl: cycle-indexed sweep model plus directed literal checks.
module tb_aoi_exp_sweep_ctrl;

  localparam int S    = 2;
  localparam int P    = 1;
  localparam int SPAN = 16 * P * (S + 1);
  localparam int N    = SPAN + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0, y_in;
  logic a, b, c, d, busy, done, pass;
  logic [3:0] vector;
  logic [4:0] err_count;
  int mode = 0;  // 0 golden, 1 stuck0, 2 stuck1, 3 inverted

  logic start2 = 1'b0, abort2 = 1'b0, y2;
  logic a2, b2, c2, d2, busy2, done2, pass2;
  logic [3:0] vector2;
  logic [4:0] err2;

`ifdef AOI_SWEEP_FAILCAP_EN
  logic [3:0] ffv, ffv2;
  logic       ffval, ffval2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    logic g;
    g = ~((a & b) | (c & d));
    case (mode)
      1:       y_in = 1'b0;
      2:       y_in = 1'b1;
      3:       y_in = ~g;
      default: y_in = g;
    endcase
  end
  assign y2 = (a2 & b2) | (c2 & d2);

  aoi_exp_sweep_ctrl #(.SETTLE_CYCLES(S), .NUM_PASSES(P)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .y_in(y_in),
    .a(a), .b(b), .c(c), .d(d), .vector(vector), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count)
`ifdef AOI_SWEEP_FAILCAP_EN
    , .first_fail_vec(ffv), .first_fail_valid(ffval)
`endif
  );

  aoi_exp_sweep_ctrl #(.SETTLE_CYCLES(2), .NUM_PASSES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .y_in(y2),
    .a(a2), .b(b2), .c(c2), .d(d2), .vector(vector2), .busy(busy2), .done(done2),
    .pass(pass2), .err_count(err2)
`ifdef AOI_SWEEP_FAILCAP_EN
    , .first_fail_vec(ffv2), .first_fail_valid(ffval2)
`endif
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int mism(input int v, input int md);
    logic [3:0] vv;
    logic g;
    vv = 4'(v);
    g = ~((vv[3] & vv[2]) | (vv[1] & vv[0]));
    case (md)
      1:       return int'(g);
      2:       return int'(!g);
      3:       return 1;
      default: return 0;
    endcase
  endfunction

  // Mismatches counted after k edges of a sweep: one sample completes every S+1 edges.
  function automatic int errs(input int k, input int md);
    int e = 0;
    for (int j = 0; j < k / (S + 1); j++) e += mism(j % 16, md);
    return (e > 31) ? 31 : e;
  endfunction

  bit m_active = 0, m_done = 0, m_pass = 0;
  int m_k = 0, m_err = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_done = 0; m_pass = 0; m_k = 0; m_err = 0;
    end else if (m_active) begin
      if (abort) begin
        m_err = errs(m_k, mode);
        m_active = 0;
      end else begin
        m_k++;
        if (m_k == N) begin
          m_active = 0;
          m_done = 1;
          m_err = errs(SPAN, mode);
          m_pass = (m_err == 0);
        end
      end
    end else begin
      m_done = 0;
      if (start && !abort) begin
        m_active = 1; m_k = 0; m_pass = 0;
      end
    end
  end

  always @(negedge clk) begin
    int ev, eb, ed, ep, ee;
    if (rst_n) begin
      if (m_active) begin
        ev = (m_k < SPAN) ? (m_k / (S + 1)) % 16 : 15;
        eb = 1; ed = 0; ep = 0;
        ee = errs((m_k < SPAN) ? m_k : SPAN, mode);
      end else begin
        ev = 0; eb = 0; ed = int'(m_done); ep = int'(m_pass); ee = m_err;
      end
      chk("m_vector", int'(vector), ev);
      chk("m_abcd", int'({a, b, c, d}), ev);
      chk("m_busy", int'(busy), eb);
      chk("m_done", int'(done), ed);
      chk("m_pass", int'(pass), ep);
      chk("m_err", int'(err_count), ee);
    end
  end

  task automatic launch();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run(input int md, output int cyc);
    mode = md;
    launch();
    cyc = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin cyc = i; break; end
    end
    if (cyc < 0) begin
      errors++;
      $display("FAIL done_timeout actual=none expected=pulse");
    end
  endtask

  task automatic wait_k(input int k);
    for (int i = 0; i <= k; i++) @(negedge clk);
  endtask

  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_vector", int'(vector), 0);
    chk("rst_err", int'(err_count), 0);
    chk("rst_pass", int'(pass), 0);

    run(0, cyc);
    chk("t1_latency", cyc, 49);
    chk("t1_pass", int'(pass), 1);
    chk("t1_err", int'(err_count), 0);

    run(1, cyc);
    chk("t2_err", int'(err_count), 9);
    chk("t2_pass", int'(pass), 0);
`ifdef AOI_SWEEP_FAILCAP_EN
    chk("t2_ffv", int'(ffv), 0);
    chk("t2_ffval", int'(ffval), 1);
`endif

    run(2, cyc);
    chk("t3_err", int'(err_count), 7);
    chk("t3_pass", int'(pass), 0);
`ifdef AOI_SWEEP_FAILCAP_EN
    chk("t3_ffv", int'(ffv), 3);
`endif

    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", int'(busy), 0);

    mode = 1;
    launch();
    for (int i = 0; i <= 17; i++) begin
      @(negedge clk);
      if (i == 8) start = 1'b1;
      if (i == 9) start = 1'b0;
    end
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("t5_busy", int'(busy), 0);
    chk("t5_abcd", int'({a, b, c, d}), 0);
    chk("t5_done", int'(done), 0);
    chk("t5_err", int'(err_count), 4);
    repeat (40) @(negedge clk);
    chk("t5_err_hold", int'(err_count), 4);

    mode = 1;
    launch();
    wait_k(27);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy", int'(busy), 0);
    chk("t6_abcd", int'({a, b, c, d}), 0);
    chk("t6_vector", int'(vector), 0);
    chk("t6_err", int'(err_count), 0);
    chk("t6_done", int'(done), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    run(0, cyc);
    chk("t6_latency", cyc, 49);
    chk("t6_pass", int'(pass), 1);

    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    cyc = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (i == 60) chk("t4_sat_mid", int'(err2), 20);
      if (done2) begin cyc = i; break; end
    end
    if (cyc < 0) begin
      errors++;
      $display("FAIL t4_timeout actual=none expected=pulse");
    end
    chk("t4_latency", cyc, 97);
    chk("t4_err", int'(err2), 31);
    chk("t4_pass", int'(pass2), 0);
    @(negedge clk);
    chk("t4_busy_after", int'(busy2), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
